// File: rtl/register_file.sv
// Architectural register file with ROB rename tags, commit release and flush.
// Optional same-cycle commit bypass on queries: define RF_BYPASS_EN.
module register_file #(
    parameter int ROB_SIZE_BIT = 5
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    rob_clear,
    input  logic                    is_update_val,
    input  logic [4:0]              update_val_id,
    input  logic [ROB_SIZE_BIT-1:0] update_val_dep,
    input  logic [31:0]             update_val,
    input  logic                    is_update_dep,
    input  logic [4:0]              update_dep_id,
    input  logic [ROB_SIZE_BIT-1:0] update_dep,
    input  logic [4:0]              rf_qry1_id,
    input  logic [4:0]              rf_qry2_id,
    output logic                    rf_qry1_busy,
    output logic                    rf_qry2_busy,
    output logic [ROB_SIZE_BIT-1:0] rf_qry1_dep,
    output logic [ROB_SIZE_BIT-1:0] rf_qry2_dep,
    output logic [31:0]             rf_qry1_val,
    output logic [31:0]             rf_qry2_val
);

    logic [31:0]             val_q  [32];
    logic                    busy_q [32];
    logic [ROB_SIZE_BIT-1:0] dep_q  [32];

    logic commit_en;
    logic rename_en;
    logic release_en;

    assign commit_en  = rdy_in && !rob_clear && is_update_val
                        && (update_val_id != 5'd0);
    assign rename_en  = rdy_in && !rob_clear && is_update_dep
                        && (update_dep_id != 5'd0);
    assign release_en = commit_en && busy_q[update_val_id]
                        && (dep_q[update_val_id] == update_val_dep);

    // Rename is written after the release so it wins on the same register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                val_q[i]  <= '0;
                busy_q[i] <= 1'b0;
                dep_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (rob_clear) begin
                for (int i = 0; i < 32; i++) begin
                    busy_q[i] <= 1'b0;
                    dep_q[i]  <= '0;
                end
            end else begin
                if (commit_en) begin
                    val_q[update_val_id] <= update_val;
                end
                if (release_en) begin
                    busy_q[update_val_id] <= 1'b0;
                end
                if (rename_en) begin
                    busy_q[update_dep_id] <= 1'b1;
                    dep_q[update_dep_id]  <= update_dep;
                end
            end
        end
    end

    logic [4:0]              qid    [2];
    logic                    q_busy [2];
    logic [ROB_SIZE_BIT-1:0] q_dep  [2];
    logic [31:0]             q_val  [2];

    assign qid[0] = rf_qry1_id;
    assign qid[1] = rf_qry2_id;

    always_comb begin
        for (int q = 0; q < 2; q++) begin
            q_busy[q] = busy_q[qid[q]];
            q_dep[q]  = dep_q[qid[q]];
            q_val[q]  = val_q[qid[q]];
            if (qid[q] == 5'd0) begin
                q_busy[q] = 1'b0;
                q_dep[q]  = '0;
                q_val[q]  = '0;
            end
`ifdef RF_BYPASS_EN
            else if (release_en && (qid[q] == update_val_id)) begin
                q_busy[q] = 1'b0;
                q_val[q]  = update_val;
            end
`endif
        end
    end

    assign rf_qry1_busy = q_busy[0];
    assign rf_qry1_dep  = q_dep[0];
    assign rf_qry1_val  = q_val[0];
    assign rf_qry2_busy = q_busy[1];
    assign rf_qry2_dep  = q_dep[1];
    assign rf_qry2_val  = q_val[1];

endmodule

// File: tb/tb_register_file.sv
// Directed and randomized checks of register_file against a rule-level model.
module tb_register_file;

    localparam int TW = 5;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          rob_clear;
    logic          is_update_val;
    logic [4:0]    update_val_id;
    logic [TW-1:0] update_val_dep;
    logic [31:0]   update_val;
    logic          is_update_dep;
    logic [4:0]    update_dep_id;
    logic [TW-1:0] update_dep;
    logic [4:0]    rf_qry1_id;
    logic [4:0]    rf_qry2_id;
    logic          rf_qry1_busy;
    logic          rf_qry2_busy;
    logic [TW-1:0] rf_qry1_dep;
    logic [TW-1:0] rf_qry2_dep;
    logic [31:0]   rf_qry1_val;
    logic [31:0]   rf_qry2_val;

    register_file #(.ROB_SIZE_BIT(TW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_clear(rob_clear),
        .is_update_val(is_update_val), .update_val_id(update_val_id),
        .update_val_dep(update_val_dep), .update_val(update_val),
        .is_update_dep(is_update_dep), .update_dep_id(update_dep_id),
        .update_dep(update_dep),
        .rf_qry1_id(rf_qry1_id), .rf_qry2_id(rf_qry2_id),
        .rf_qry1_busy(rf_qry1_busy), .rf_qry2_busy(rf_qry2_busy),
        .rf_qry1_dep(rf_qry1_dep), .rf_qry2_dep(rf_qry2_dep),
        .rf_qry1_val(rf_qry1_val), .rf_qry2_val(rf_qry2_val)
    );

    always #5 clk_in = ~clk_in;

    int total  = 0;
    int passed = 0;

    logic [31:0]   m_val  [32];
    logic          m_busy [32];
    logic [TW-1:0] m_dep  [32];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_dep[i] = '0;
        end
    endtask

    // What a source read should see this cycle, from the rules alone.
    task automatic expect_q(input logic [4:0] id, output logic b,
                            output logic [TW-1:0] d, output logic [31:0] v);
        b = m_busy[id]; d = m_dep[id]; v = m_val[id];
        if (id == 0) begin
            b = 0; d = 0; v = 0;
        end
`ifdef RF_BYPASS_EN
        else if (rdy_in && !rob_clear && is_update_val
                 && id == update_val_id && b && d == update_val_dep) begin
            b = 0; v = update_val;
        end
`endif
    endtask

    task automatic check_port(input int p, input logic [4:0] id,
                              input logic ob, input logic [TW-1:0] od,
                              input logic [31:0] ov);
        logic b; logic [TW-1:0] d; logic [31:0] v;
        expect_q(id, b, d, v);
        check($sformatf("q%0d_busy x%0d", p, id), 32'(ob), 32'(b));
        if (b) check($sformatf("q%0d_dep x%0d", p, id), 32'(od), 32'(d));
        check($sformatf("q%0d_val x%0d", p, id), ov, v);
    endtask

    task automatic model_clock();
        if (!rdy_in) return;
        if (rob_clear) begin
            for (int i = 0; i < 32; i++) begin
                m_busy[i] = 0; m_dep[i] = 0;
            end
            return;
        end
        if (is_update_val && update_val_id != 0) begin
            m_val[update_val_id] = update_val;
            if (m_busy[update_val_id] && m_dep[update_val_id] == update_val_dep)
                m_busy[update_val_id] = 0;
        end
        if (is_update_dep && update_dep_id != 0) begin
            m_busy[update_dep_id] = 1;
            m_dep[update_dep_id]  = update_dep;
        end
    endtask

    // Inputs are set at the negedge; outputs sampled 2ns later.
    task automatic cyc();
        #2;
        check_port(1, rf_qry1_id, rf_qry1_busy, rf_qry1_dep, rf_qry1_val);
        check_port(2, rf_qry2_id, rf_qry2_busy, rf_qry2_dep, rf_qry2_val);
        @(posedge clk_in);
        model_clock();
        @(negedge clk_in);
    endtask

    task automatic idle();
        rdy_in = 1; rob_clear = 0;
        is_update_val = 0; update_val_id = 0; update_val_dep = 0; update_val = 0;
        is_update_dep = 0; update_dep_id = 0; update_dep = 0;
    endtask

    task automatic commit(input logic [4:0] id, input logic [TW-1:0] t,
                          input logic [31:0] v);
        is_update_val = 1; update_val_id = id; update_val_dep = t; update_val = v;
    endtask

    task automatic rename(input logic [4:0] id, input logic [TW-1:0] t);
        is_update_dep = 1; update_dep_id = id; update_dep = t;
    endtask

    initial begin
        model_reset();
        idle();
        rst_in = 1; rdy_in = 0; rob_clear = 1;
        rf_qry1_id = 5; rf_qry2_id = 9;
        @(negedge clk_in); #1;
        check("rst_busy", 32'(rf_qry1_busy), 0);
        check("rst_val", rf_qry2_val, 0);
        idle();
        rst_in = 0;
        #1;
        check("post_rst_dep", 32'(rf_qry1_dep), 0);
        @(negedge clk_in);

        // Rename then commit of the owning tag
        rename(5, 3); cyc(); idle();
        rf_qry1_id = 5; #1;
        check("x5_busy", 32'(rf_qry1_busy), 1);
        check("x5_dep", 32'(rf_qry1_dep), 3);
        commit(5, 3, 32'hDEADBEEF); cyc(); idle(); #1;
        check("x5_rel_busy", 32'(rf_qry1_busy), 0);
        check("x5_rel_val", rf_qry1_val, 32'hDEADBEEF);
        @(negedge clk_in);

        // Older commit must not release a younger rename
        rename(7, 2); cyc(); idle();
        rename(7, 4); cyc(); idle();
        commit(7, 2, 32'h11); rf_qry2_id = 7; cyc(); idle(); #1;
        check("x7_val", rf_qry2_val, 32'h11);
        check("x7_busy", 32'(rf_qry2_busy), 1);
        check("x7_dep", 32'(rf_qry2_dep), 4);
        @(negedge clk_in);

        // Commit and rename same register, same cycle
        commit(9, 1, 32'h55); rename(9, 6); rf_qry1_id = 9; cyc(); idle(); #1;
        check("x9_busy", 32'(rf_qry1_busy), 1);
        check("x9_dep", 32'(rf_qry1_dep), 6);
        check("x9_val", rf_qry1_val, 32'h55);
        @(negedge clk_in);

        // Flush drops commits and clears all busy
        rename(1, 1); cyc(); idle();
        rename(2, 2); cyc(); idle();
        rename(3, 3); cyc(); idle();
        rob_clear = 1; commit(1, 1, 32'h99); rename(2, 9); cyc(); idle();
        rf_qry1_id = 1; rf_qry2_id = 2; #1;
        check("flush_b1", 32'(rf_qry1_busy), 0);
        check("flush_v1", rf_qry1_val, 0);
        check("flush_b2", 32'(rf_qry2_busy), 0);
        @(negedge clk_in);

        // Writes to x0 are ignored
        commit(0, 0, 32'h1234); rename(0, 5); rf_qry1_id = 0; cyc(); idle(); #1;
        check("x0_busy", 32'(rf_qry1_busy), 0);
        check("x0_val", rf_qry1_val, 0);
        @(negedge clk_in);

        // Commit release seen through a same-cycle query
        rename(4, 7); cyc(); idle();
        commit(4, 7, 32'hABCD); rf_qry1_id = 4; #1;
`ifdef RF_BYPASS_EN
        check("x4_byp_busy", 32'(rf_qry1_busy), 0);
        check("x4_byp_val", rf_qry1_val, 32'hABCD);
`else
        check("x4_nobyp_busy", 32'(rf_qry1_busy), 1);
        check("x4_nobyp_dep", 32'(rf_qry1_dep), 7);
`endif
        cyc(); idle(); #1;
        check("x4_next_busy", 32'(rf_qry1_busy), 0);
        check("x4_next_val", rf_qry1_val, 32'hABCD);
        @(negedge clk_in);

        // rdy_in low freezes state
        rdy_in = 0; rename(4, 2); commit(5, 0, 32'h7); cyc(); idle();

        // Random traffic concentrated on a few registers
        for (int n = 0; n < 600; n++) begin
            logic [4:0] cid;
            cid = 5'($urandom_range(0, 7));
            rdy_in    = ($urandom_range(0, 9) != 0);
            rob_clear = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 1)
                commit(cid, ($urandom_range(0, 2) != 0) ? m_dep[cid] : TW'($urandom),
                       $urandom);
            if ($urandom_range(0, 1) == 1)
                rename(5'($urandom_range(0, 7)), TW'($urandom));
            rf_qry1_id = ($urandom_range(0, 1) == 1) ? cid : 5'($urandom_range(0, 7));
            rf_qry2_id = 5'($urandom_range(0, 31));
            cyc();
            idle();
        end

        // Asynchronous reset between clock edges
        rename(6, 5); commit(6, 0, 32'hCAFE); cyc(); idle();
        rf_qry1_id = 6; rf_qry2_id = 5;
        #2; rst_in = 1; #1;
        check("arst_busy", 32'(rf_qry1_busy), 0);
        check("arst_val6", rf_qry1_val, 0);
        check("arst_val5", rf_qry2_val, 0);
        model_reset();
        @(negedge clk_in);
        rst_in = 0;
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: `ROB_SIZE_BIT, default 5 (from Config.v), ROB tag width.
REQ-002 clk_in  input  1  system clock.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 rdy_in  input  1  ready; when low, all state holds.
REQ-005 rob_clear  input  1  flush pulse from ROB after a mispredict.
REQ-006 is_update_val  input  1  commit write strobe from ROB.
REQ-007 update_val_id  input  5  committed destination register.
REQ-008 update_val_dep  input  `ROB_SIZE_BIT  ROB tag of the committing entry.
REQ-009 update_val  input  32  committed value.
REQ-010 is_update_dep  input  1  rename strobe from ROB.
REQ-011 update_dep_id  input  5  renamed destination register.
REQ-012 update_dep  input  `ROB_SIZE_BIT  ROB tag now owning the register.
REQ-013 rf_qry1_id / rf_qry2_id  input  5  source-register queries from Decoder.
REQ-014 rf_qry1_busy / rf_qry2_busy  output  1  register awaits an in-flight ROB entry.
REQ-015 rf_qry1_dep / rf_qry2_dep  output  `ROB_SIZE_BIT  owning ROB tag; valid when busy=1.
REQ-016 rf_qry1_val / rf_qry2_val  output  32  architectural value; valid when busy=0.

Function
REQ-017 Storage: 32 entries of {val[31:0], busy, dep[`ROB_SIZE_BIT-1:0]}; all state updates on posedge clk_in when rdy_in=1.
REQ-018 Register x0: val=0, busy=0 forever; commits and renames to x0 are ignored; queries of x0 return busy=0, val=0, dep=0.
REQ-019 Commit (is_update_val=1, id!=0): val[id] <= update_val next cycle, regardless of busy/dep.
REQ-020 Commit busy release: busy[id] <= 0 only if busy[id]=1 and dep[id]==update_val_dep; otherwise busy/dep unchanged (a younger rename owns the register).
REQ-021 Rename (is_update_dep=1, id!=0): busy[id] <= 1, dep[id] <= update_dep next cycle.
REQ-022 Simultaneous commit and rename to the same register: value written from commit; busy=1 and dep=update_dep from rename (rename wins).
REQ-023 Simultaneous commit and rename to different registers: both applied independently.
REQ-024 Flush: rob_clear=1 (with rdy_in=1) -> every busy <= 0, every dep <= 0, val unchanged; is_update_val and is_update_dep are ignored that cycle.
REQ-025 Queries are combinational (zero-cycle latency) from current state plus bypass per REQ-030.
REQ-026 A rename in the current cycle does NOT affect query outputs in that cycle (sources see pre-rename state, so an instruction reading its own rd sees the previous owner).
REQ-027 Query of a register whose dep tag matches an uncommitted entry returns busy=1, dep=tag, val=stale architectural value.
REQ-028 rdy_in=0: no state change; query outputs still reflect stored state.

Reset
REQ-029 rst_in=1 asynchronously sets all val=0, busy=0, dep=0; outputs therefore read busy=0, dep=0, val=0 for every query while reset is held and immediately after release; rst_in overrides rob_clear and rdy_in.

Configuration
REQ-030 Macro RF_BYPASS_EN defined: if is_update_val=1, rob_clear=0, query id==update_val_id!=0, busy[id]=1 and dep[id]==update_val_dep, the query returns busy=0, val=update_val in the same cycle; not defined: queries return stored state only, the released value visible one cycle later.

Verification
REQ-031 Rename x5->tag 3, next cycle query x5 -> busy=1, dep=3; commit x5 tag 3 val 0xDEADBEEF -> next cycle query x5 busy=0, val=0xDEADBEEF.
REQ-032 Rename x7->tag 2, then x7->tag 4; commit x7 tag 2 val 0x11 -> val=0x11, busy=1, dep=4 retained.
REQ-033 Same cycle: commit x9 tag 1 val 0x55 and rename x9->tag 6 -> next cycle busy=1, dep=6, val=0x55.
REQ-034 Rename x1,x2,x3 busy; assert rob_clear with is_update_val x1 val 0x99 -> all busy=0, x1 val unchanged (not 0x99).
REQ-035 Commit x0 val 0x1234 and rename x0 tag 5 -> query x0 returns busy=0, val=0.
REQ-036 With RF_BYPASS_EN: x4 busy tag 7, commit x4 tag 7 val 0xABCD while querying x4 -> same cycle busy=0, val=0xABCD; without macro -> busy=1, dep=7 that cycle, busy=0 next cycle.
